// File: rtl/tspi_tx_shift_if.sv
// Signal bundle between the SPI transmit controller (master) and the transmit shifter (slave).
interface tspi_tx_shift_if #(
    parameter int DATA_W = 32,
    parameter int SPI0_2 = 32
);
    logic              csn_en;
    logic [DATA_W-1:0] tx_data;
    logic [7:0]        bit_len;
    logic [SPI0_2-1:0] half_div;
    logic [SPI0_2-1:0] del_css;
    logic              cpol;
    logic              SCLK;
    logic              MOSI;
    logic              csn_cmpt;
    logic              busy;

    modport master (
        output csn_en, tx_data, bit_len, half_div, del_css, cpol,
        input  SCLK, MOSI, csn_cmpt, busy
    );

    modport slave (
        input  csn_en, tx_data, bit_len, half_div, del_css, cpol,
        output SCLK, MOSI, csn_cmpt, busy
    );
endinterface

// File: rtl/tspi_tx_shift.sv
// SPI transmit shifter, CPHA=0, MSB first: frame starts on csn_en, ends with a one-cycle csn_cmpt.
// csn_cmpt lands del_css+2+(2N+1)*H cycles after start; csn_en low mid-frame aborts silently.
module tspi_tx_shift #(
    parameter int DATA_W = 32,
    parameter int SPI0_2 = 32
) (
    input  logic            clk,
    input  logic            rst,
    tspi_tx_shift_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TAIL,
        S_DONE
    } state_t;

    localparam logic [7:0]        W8  = 8'(DATA_W);
    localparam logic [SPI0_2-1:0] ONE = SPI0_2'(1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [DATA_W-1:0] aligned;
    logic [7:0]        n_in;
    logic [7:0]        n_q;
    logic [7:0]        bit_cnt;
    logic [SPI0_2-1:0] cnt;
    logic [SPI0_2-1:0] half_q;
    logic [SPI0_2-1:0] del_q;
    logic              cpol_q;

    // The word is left-aligned so the current bit is always the register MSB.
    always_comb begin
        n_in = bus.bit_len;
        if (bus.bit_len == 8'd0 || bus.bit_len > W8) begin
            n_in = W8;
        end
        aligned = bus.tx_data << (W8 - n_in);
    end

    assign shreg_nxt = shreg << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            bus.SCLK     <= 1'b0;
            bus.MOSI     <= 1'b0;
            bus.csn_cmpt <= 1'b0;
            bus.busy     <= 1'b0;
            shreg        <= '0;
            n_q          <= '0;
            bit_cnt      <= '0;
            cnt          <= '0;
            half_q       <= '0;
            del_q        <= '0;
            cpol_q       <= 1'b0;
        end else begin
            bus.csn_cmpt <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.SCLK <= bus.cpol;
                    bus.MOSI <= 1'b0;
                    if (bus.csn_en) begin
                        shreg    <= aligned;
                        n_q      <= n_in;
                        half_q   <= bus.half_div;
                        del_q    <= bus.del_css;
                        cpol_q   <= bus.cpol;
                        bus.MOSI <= aligned[DATA_W-1];
                        bit_cnt  <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_LEAD;
                    end
                end

                S_LEAD, S_SHIFT, S_TAIL: begin
                    if (!bus.csn_en) begin
                        bus.SCLK <= cpol_q;
                        bus.MOSI <= 1'b0;
                        bus.busy <= 1'b0;
                        cnt      <= '0;
                        state    <= S_IDLE;
                    end else if (state == S_LEAD) begin
                        if (cnt == del_q) begin
                            cnt   <= '0;
                            state <= S_SHIFT;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end else if (state == S_SHIFT) begin
                        if (cnt == half_q) begin
                            cnt      <= '0;
                            bus.SCLK <= ~bus.SCLK;
                            // Data only moves on the edge that returns SCLK to idle.
                            if (bus.SCLK != cpol_q) begin
                                if (bit_cnt == n_q - 8'd1) begin
                                    state <= S_TAIL;
                                end else begin
                                    shreg    <= shreg_nxt;
                                    bus.MOSI <= shreg_nxt[DATA_W-1];
                                    bit_cnt  <= bit_cnt + 8'd1;
                                end
                            end
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end else begin
                        bus.SCLK <= cpol_q;
                        if (cnt == half_q) begin
                            cnt          <= '0;
                            bus.csn_cmpt <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end

                S_DONE: begin
                    bus.MOSI <= 1'b0;
                    if (!bus.csn_en) begin
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tspi_tx_shift.sv
// Scoreboarded bench for tspi_tx_shift: stimulus queues expected busy/SCLK/csn_cmpt events, a monitor pops them.
module tb_tspi_tx_shift;
    localparam int EV_RISE = 0;
    localparam int EV_EDGE = 1;
    localparam int EV_CMPT = 2;
    localparam int EV_FALL = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tspi_tx_shift_if #(.DATA_W(32), .SPI0_2(32)) bus();
    tspi_tx_shift #(.DATA_W(32), .SPI0_2(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ev_t  exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   frame_edges = 0;
    int   cmpt_seen = 0;
    bit   mon_en = 1'b0;
    logic prev_sclk = 1'b0;
    logic prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int v);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input string name, input int kind, input logic [31:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: unexpected event at cycle %0d, none expected", name, cyc);
            return;
        end
        e = exp_q.pop_front();
        check({name, " kind"}, kind, e.kind);
        check({name, " cycle"}, cyc, e.cyc);
        if (kind != EV_CMPT) check({name, " sclk_mosi"}, val, e.val);
    endtask

    // Events are encoded as {SCLK, MOSI} sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.busy !== prev_busy)
                expect_ev(bus.busy ? "busy_rise" : "busy_fall", bus.busy ? EV_RISE : EV_FALL,
                          {30'd0, bus.SCLK, bus.MOSI});
            if (bus.busy === 1'b1 && bus.SCLK !== prev_sclk) begin
                frame_edges++;
                expect_ev("sclk_edge", EV_EDGE, {30'd0, bus.SCLK, bus.MOSI});
            end
            if (bus.csn_cmpt === 1'b1) begin
                cmpt_seen++;
                expect_ev("csn_cmpt", EV_CMPT, 32'd0);
            end
        end
        prev_busy = bus.busy;
        prev_sclk = bus.SCLK;
    end

    // Expected frame: busy rise with first bit, then 2N edges every H cycles from del_css+2+H.
    task automatic push_frame(input int t0, input logic [31:0] d, input int n, input int h,
                              input int dl, input int cp, input int max_e, input int cmpt_rel);
        int i;
        int v;
        push(EV_RISE, t0 + 1, cp * 2 + int'(d[n-1]));
        for (int k = 1; k <= 2 * n; k++) begin
            if (k <= max_e) begin
                i = (k - 1) / 2;
                if (k % 2 == 1)   v = (1 - cp) * 2 + int'(d[n-1-i]);
                else if (i < n-1) v = cp * 2 + int'(d[n-2-i]);
                else              v = cp * 2 + int'(d[n-1-i]);
                push(EV_EDGE, t0 + dl + 2 + k * h, v);
            end
        end
        if (cmpt_rel >= 0) push(EV_CMPT, t0 + cmpt_rel, 0);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic set_cpol(input logic cp);
        bus.cpol = cp;
        idle(2);
    endtask

    // Called #1 after a posedge; returns #1 after the posedge where csn_en is dropped.
    task automatic run_frame(input logic [31:0] data, input int bl, input int hd, input int dc,
                             input int cp, input int n, input int cmpt_rel, input int hold);
        int t0;
        int c0;
        bus.tx_data  = data;
        bus.bit_len  = 8'(bl);
        bus.half_div = 32'(hd);
        bus.del_css  = 32'(dc);
        bus.csn_en   = 1'b1;
        t0 = cyc;
        c0 = cmpt_seen;
        frame_edges = 0;
        push_frame(t0, data, n, hd + 1, dc, cp, 2 * n, cmpt_rel);
        repeat (cmpt_rel + hold) @(posedge clk);
        #1;
        check("edge_count", frame_edges, 2 * n);
        check("cmpt_count", cmpt_seen - c0, 1);
        bus.csn_en = 1'b0;
        push(EV_FALL, cyc + 1, cp * 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int c0;
        int w;
        bus.csn_en   = 1'b0;
        bus.tx_data  = '0;
        bus.bit_len  = '0;
        bus.half_div = '0;
        bus.del_css  = '0;
        bus.cpol     = 1'b1;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sclk", bus.SCLK, 0);
        check("rst_mosi", bus.MOSI, 0);
        check("rst_cmpt", bus.csn_cmpt, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Mode 0, 0xA5
        set_cpol(1'b0);
        run_frame(32'hA5, 8, 1, 0, 0, 8, 36, 1);
        idle(3);
        check("drain_mode0", exp_q.size(), 0);

        // Mode 2 with lead
        set_cpol(1'b1);
        run_frame(32'h0000000C, 4, 0, 3, 1, 4, 14, 1);
        idle(3);
        check("drain_mode2", exp_q.size(), 0);

        // Full width via bit_len=0, then via bit_len above DATA_W
        set_cpol(1'b0);
        run_frame(32'h80000001, 0, 0, 0, 0, 32, 67, 1);
        idle(3);
        check("drain_full", exp_q.size(), 0);
        run_frame(32'hF0F00001, 40, 0, 1, 0, 32, 68, 1);
        idle(3);
        check("drain_over", exp_q.size(), 0);

        // Retrigger guard: hold csn_en 20 cycles past csn_cmpt, then a single low cycle
        run_frame(32'h0000003C, 6, 0, 1, 0, 6, 16, 21);
        @(posedge clk);
        #1;
        run_frame(32'h00000096, 8, 2, 2, 0, 8, 55, 1);
        idle(3);
        check("drain_retrig", exp_q.size(), 0);

        // Abort after the third SCLK edge
        set_cpol(1'b1);
        bus.tx_data  = 32'hB4;
        bus.bit_len  = 8'd8;
        bus.half_div = 32'd3;
        bus.del_css  = 32'd1;
        bus.csn_en   = 1'b1;
        t0 = cyc;
        c0 = cmpt_seen;
        frame_edges = 0;
        push_frame(t0, 32'hB4, 8, 4, 1, 1, 3, -1);
        w = 0;
        while (frame_edges < 3 && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("abort_reach3", frame_edges, 3);
        bus.csn_en = 1'b0;
        push(EV_FALL, cyc + 1, 2);
        @(posedge clk);
        @(negedge clk);
        check("abort_sclk", bus.SCLK, 1);
        check("abort_mosi", bus.MOSI, 0);
        check("abort_busy", bus.busy, 0);
        idle(30);
        check("abort_no_cmpt", cmpt_seen - c0, 0);
        check("abort_edges", frame_edges, 3);
        check("drain_abort", exp_q.size(), 0);

        // Reset during S_SHIFT, between edges 2 and 3
        bus.tx_data  = 32'h5A;
        bus.bit_len  = 8'd8;
        bus.half_div = 32'd1;
        bus.del_css  = 32'd0;
        bus.csn_en   = 1'b1;
        t0 = cyc;
        c0 = cmpt_seen;
        frame_edges = 0;
        push_frame(t0, 32'h5A, 8, 2, 0, 1, 2, -1);
        idle(7);
        rst = 1'b1;
        bus.csn_en = 1'b0;
        push(EV_FALL, t0 + 8, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_sclk", bus.SCLK, 0);
        check("midrst_mosi", bus.MOSI, 0);
        check("midrst_cmpt", bus.csn_cmpt, 0);
        check("midrst_busy", bus.busy, 0);
        idle(3);
        check("midrst_no_cmpt", cmpt_seen - c0, 0);
        check("drain_midrst", exp_q.size(), 0);
        run_frame(32'h81, 8, 0, 0, 1, 8, 19, 1);
        idle(3);
        check("drain_post_rst", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
